// File: rtl/multi_debouncer.sv
// N-channel pushbutton conditioner: synchronise, debounce and edge-detect each input,
// with press/release pulses and a long-press hold pulse that can auto-repeat.
module multi_debouncer #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold_pulse,
  output logic            any_pressed
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;
  localparam logic [TW-1:0] REP_LAST = (REPEAT_CYCLES > 0) ? TW'(REPEAT_CYCLES - 1) : '0;

  logic [N_CH-1:0] level_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]    sync;
    logic          p_sync;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          lvl_q;
    logic          press_q;
    logic          rel_q;
    logic          hold_q;
    logic [TW-1:0] timer;
    state_t        state;

    // Counting D mismatching cycles (terminal value reached on the D-th) gives
    // acceptance exactly 1+D edges after the raw change is first sampled.
    assign p_sync        = sync[1] ^ IDLE_RAW;
    assign accept        = (p_sync != lvl_q) && (cnt == CNT_LAST);
    assign level_next[i] = accept ? p_sync : lvl_q;

    assign level[i]         = lvl_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign hold_pulse[i]    = hold_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync    <= {2{IDLE_RAW}};
        cnt     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hold_q  <= 1'b0;
        timer   <= '0;
        state   <= IDLE;
      end else begin
        sync    <= {sync[0], button[i]};
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hold_q  <= 1'b0;

        if (p_sync == lvl_q || accept) cnt <= '0;
        else                           cnt <= cnt + 1'b1;

        // An accepted release wins over a hold timer expiring on the same edge.
        if (accept) begin
          lvl_q <= p_sync;
          timer <= '0;
          if (p_sync) begin
            press_q <= 1'b1;
            state   <= PRESSED;
          end else begin
            rel_q <= 1'b1;
            state <= IDLE;
          end
        end else begin
          case (state)
            PRESSED: begin
              if (HOLD_CYCLES > 0) begin
                if (timer == HOLD_LAST) begin
                  hold_q <= 1'b1;
                  state  <= HELD;
                  timer  <= '0;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
            end
            HELD: begin
              if (REPEAT_CYCLES > 0) begin
                if (timer == REP_LAST) begin
                  hold_q <= 1'b1;
                  timer  <= '0;
                end else begin
                  timer <= timer + 1'b1;
                end
              end else if (timer != '1) begin
                timer <= timer + 1'b1;
              end
            end
            default: timer <= '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_pressed <= 1'b0;
    else       any_pressed <= |level_next;
  end

endmodule
